// File: rtl/mult_engine_arbiter_pkg.sv
// Shared constants and FSM encoding for the mult_top engine arbiter.
// VECTOR_SIZE mirrors the `VECTOR_SIZE default of matrix_vector_mult_parameters.v.
package mult_engine_arbiter_pkg;

  localparam int unsigned VECTOR_SIZE    = 32;
  localparam int unsigned ITER_W         = 16;
  localparam int unsigned TIMEOUT_CYCLES = 1048576;
  localparam int unsigned TO_W           = 21;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StStart = 3'd2,
    StRun   = 3'd3,
    StResp  = 3'd4
  } state_e;

endpackage

// File: rtl/mult_engine_arbiter_rr.sv
// Combinational round-robin picker: first set req bit searching upward from
// (last + 1) mod NUM_REQ, returned both one-hot and as a binary index.
module rr_arbiter_onehot #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    grant    = '0;
    index    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(last) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        index           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mult_engine_arbiter.sv
// Shares one mult_top engine among NUM_REQ channels: round-robin grant, operand
// latch, start pulse, done wait with watchdog, and result return to the winner.
module mult_engine_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned VECTOR_SIZE    = mult_engine_arbiter_pkg::VECTOR_SIZE,
  parameter int unsigned ITER_W         = mult_engine_arbiter_pkg::ITER_W,
  parameter int unsigned TIMEOUT_CYCLES = mult_engine_arbiter_pkg::TIMEOUT_CYCLES,
  parameter int unsigned TO_W           = mult_engine_arbiter_pkg::TO_W
) (
  input  logic                           down_clk,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ITER_W-1:0]      req_iter,
  input  logic [NUM_REQ*VECTOR_SIZE-1:0] req_vec,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [VECTOR_SIZE-1:0]         resp_data,
  output logic                           resp_err,
  output logic                           busy,
  output logic                           eng_start,
  output logic [ITER_W-1:0]              eng_max_iteration,
  output logic [VECTOR_SIZE-1:0]         eng_data_in,
  input  logic [VECTOR_SIZE-1:0]         eng_data_o,
  input  logic                           eng_done
);

  import mult_engine_arbiter_pkg::*;

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [VECTOR_SIZE-1:0]  data_in_q, data_in_d;
  logic [ITER_W-1:0]       max_iter_q, max_iter_d;
  logic [TO_W-1:0]         wd_q, wd_d;
  logic [VECTOR_SIZE-1:0]  resp_data_q, resp_data_d;
  logic                    resp_err_q, resp_err_d;
  logic                    done_q;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_index;
  logic [ITER_W-1:0]       sel_iter;
  logic [VECTOR_SIZE-1:0]  sel_vec;

  rr_arbiter_onehot #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant),
    .index (arb_index)
  );

  // Only the winner's slice is ever read, so junk on other channels is ignored.
  assign sel_iter = req_iter[int'(idx_q)*ITER_W +: ITER_W];
  assign sel_vec  = req_vec[int'(idx_q)*VECTOR_SIZE +: VECTOR_SIZE];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    last_d      = last_q;
    data_in_d   = data_in_q;
    max_iter_d  = max_iter_q;
    wd_d        = wd_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    eng_start   = 1'b0;
    resp_valid  = '0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = arb_grant;
          idx_d   = arb_index;
          state_d = StLoad;
        end
      end
      StLoad: begin
        data_in_d  = sel_vec;
        max_iter_d = (sel_iter == '0) ? ITER_W'(1) : sel_iter;
        state_d    = StStart;
      end
      StStart: begin
        // A done left high by the previous job must clear before restarting.
        if (!eng_done) begin
          eng_start = 1'b1;
          wd_d      = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (done_q) begin
          resp_data_d = eng_data_o;
          resp_err_d  = 1'b0;
          state_d     = StResp;
        end else if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = StResp;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StResp: begin
        resp_valid = grant_q;
        // A withdrawn request drops the result with the same clean-up.
        if (resp_ready[idx_q] || !req[idx_q]) begin
          grant_d = '0;
          last_d  = idx_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge down_clk or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      idx_q       <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      data_in_q   <= '0;
      max_iter_q  <= '0;
      wd_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      data_in_q   <= data_in_d;
      max_iter_q  <= max_iter_d;
      wd_q        <= wd_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      done_q      <= eng_done;
    end
  end

  assign grant             = grant_q;
  assign busy              = (state_q != StIdle);
  assign eng_max_iteration = max_iter_q;
  assign eng_data_in       = data_in_q;
  assign resp_data         = resp_data_q;
  assign resp_err          = resp_err_q;

endmodule

// File: tb/tb_mult_engine_arbiter.sv
// Directed bench for mult_engine_arbiter with a simple engine model
// (done 10 cycles after start, result = vec*3 + iter).
module tb_mult_engine_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned VS  = 32;
  localparam int unsigned IW  = 16;
  localparam int unsigned TO  = 64;
  localparam int unsigned TOW = 7;

  logic              down_clk = 1'b0;
  logic              RST;
  logic [N-1:0]      req;
  logic [N*IW-1:0]   req_iter;
  logic [N*VS-1:0]   req_vec;
  logic [N-1:0]      grant;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [VS-1:0]     resp_data;
  logic              resp_err;
  logic              busy;
  logic              eng_start;
  logic [IW-1:0]     eng_max_iteration;
  logic [VS-1:0]     eng_data_in;
  logic [VS-1:0]     eng_data_o;
  logic              eng_done;

  logic              eng_running = 1'b0;
  int unsigned       eng_cnt = 0;
  int unsigned       starts = 0;
  logic              never_done;
  logic              stuck_done;

  int checks = 0;
  int errors = 0;

  always #5 down_clk = ~down_clk;

  mult_engine_arbiter #(
    .NUM_REQ        (N),
    .VECTOR_SIZE    (VS),
    .ITER_W         (IW),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (TOW)
  ) dut (
    .down_clk          (down_clk),
    .RST               (RST),
    .req               (req),
    .req_iter          (req_iter),
    .req_vec           (req_vec),
    .grant             (grant),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_data         (resp_data),
    .resp_err          (resp_err),
    .busy              (busy),
    .eng_start         (eng_start),
    .eng_max_iteration (eng_max_iteration),
    .eng_data_in       (eng_data_in),
    .eng_data_o        (eng_data_o),
    .eng_done          (eng_done)
  );

  // Engine model: not reset by RST, like the real mult_top.
  always @(posedge down_clk) begin
    if (eng_start) begin
      eng_running <= 1'b1;
      eng_cnt     <= 1;
      starts      <= starts + 1;
    end else if (eng_running) begin
      eng_cnt <= eng_cnt + 1;
    end
  end

  assign eng_done   = stuck_done |
                      (eng_running && !never_done && eng_cnt >= 10 && eng_cnt <= 12);
  assign eng_data_o = eng_data_in * 32'd3 + {16'd0, eng_max_iteration};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_chan(input int ch, input logic [IW-1:0] iter, input logic [VS-1:0] vec);
    req_iter[ch*IW +: IW] = iter;
    req_vec[ch*VS +: VS]  = vec;
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (!eng_start && cyc < 50) begin
      @(negedge down_clk);
      cyc++;
    end
    check("start_seen", 64'(eng_start), 64'd1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (resp_valid == '0 && cyc < 200) begin
      @(negedge down_clk);
      cyc++;
    end
    check("valid_seen", 64'(resp_valid != '0), 64'd1);
  endtask

  task automatic finish_job(input logic [N-1:0] oh);
    resp_ready = oh;
    @(negedge down_clk);
    resp_ready = '0;
    req        = '0;
  endtask

  task automatic reset_dut();
    RST        = 1'b1;
    req        = '0;
    resp_ready = '0;
    repeat (2) @(negedge down_clk);
    RST = 1'b0;
    @(negedge down_clk);
  endtask

  typedef struct {
    int            ch;
    logic [IW-1:0] iter;
    logic [VS-1:0] vec;
    logic [IW-1:0] exp_iter;
    logic [VS-1:0] exp_data;
    int            bp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int            cyc;
    int unsigned   s0;
    logic [N-1:0]  oh;
    logic [N-1:0]  exp_order[6];
    logic [VS-1:0] held_data;

    tbl[0] = '{ch: 0, iter: 16'd3,     vec: 32'h0000_0010, exp_iter: 16'd3,     exp_data: 32'h0000_0033, bp: 0};
    tbl[1] = '{ch: 2, iter: 16'd0,     vec: 32'h1234_5678, exp_iter: 16'd1,     exp_data: 32'h369D_0369, bp: 20};
    tbl[2] = '{ch: 1, iter: 16'h00FF,  vec: 32'hFFFF_FFFF, exp_iter: 16'h00FF,  exp_data: 32'h0000_00FC, bp: 0};
    tbl[3] = '{ch: 3, iter: 16'd7,     vec: 32'h0000_0100, exp_iter: 16'd7,     exp_data: 32'h0000_0307, bp: 0};
    exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};

    RST        = 1'b1;
    req        = '0;
    resp_ready = '0;
    never_done = 1'b0;
    stuck_done = 1'b0;
    req_iter   = {N{16'hBAD0}};
    req_vec    = {N{32'hDEAD_BEEF}};
    repeat (2) @(negedge down_clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ctrl", {grant, resp_valid, eng_start, resp_err, eng_max_iteration}, 64'd0);
    check("reset_data", {eng_data_in, resp_data}, 64'd0);
    RST = 1'b0;
    @(negedge down_clk);

    // Single requests, including iteration clamp and backpressure.
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << tbl[i].ch;
      set_chan(tbl[i].ch, tbl[i].iter, tbl[i].vec);
      s0  = starts;
      req = oh;
      wait_start(cyc);
      check("start_latency", 64'(cyc), 64'd2);
      check("grant", 64'(grant), 64'(oh));
      check("max_iter", 64'(eng_max_iteration), 64'(tbl[i].exp_iter));
      check("data_in", 64'(eng_data_in), 64'(tbl[i].vec));
      @(negedge down_clk);
      check("start_one_cycle", 64'(eng_start), 64'd0);
      wait_valid(cyc);
      check("resp_valid", 64'(resp_valid), 64'(oh));
      check("resp_data", 64'(resp_data), 64'(tbl[i].exp_data));
      check("resp_err", 64'(resp_err), 64'd0);
      held_data = resp_data;
      for (int k = 0; k < tbl[i].bp; k++) begin
        @(negedge down_clk);
        check("bp_valid", 64'(resp_valid), 64'(oh));
        check("bp_data", 64'(resp_data), 64'(tbl[i].exp_data));
      end
      check("single_start_count", 64'(starts - s0), 64'd1);
      finish_job(oh);
      check("done_busy", 64'(busy), 64'd0);
      check("done_grant", {grant, resp_valid}, 64'd0);
      @(negedge down_clk);
    end

    // Contention: channels 0, 1, 3 requesting continuously.
    reset_dut();
    set_chan(0, 16'd1, 32'h1);
    set_chan(1, 16'd1, 32'h2);
    set_chan(3, 16'd1, 32'h3);
    req = 4'b1011;
    for (int j = 0; j < 6; j++) begin
      wait_valid(cyc);
      check("rr_grant", 64'(grant), 64'(exp_order[j]));
      check("rr_valid", 64'(resp_valid), 64'(exp_order[j]));
      resp_ready = resp_valid;
      @(negedge down_clk);
      resp_ready = '0;
    end
    req = '0;
    repeat (2) @(negedge down_clk);

    // Timeout, then the queued channel 2 is served normally.
    reset_dut();
    never_done = 1'b1;
    set_chan(0, 16'd4, 32'h40);
    set_chan(2, 16'd2, 32'h5);
    req = 4'b0101;
    wait_start(cyc);
    cyc = 0;
    while (resp_valid == '0 && cyc < 200) begin
      @(negedge down_clk);
      cyc++;
    end
    check("timeout_latency", 64'(cyc), 64'd65);
    check("timeout_valid", 64'(resp_valid), 64'b0001);
    check("timeout_err", 64'(resp_err), 64'd1);
    check("timeout_data", 64'(resp_data), 64'd0);
    never_done = 1'b0;
    resp_ready = 4'b0001;
    @(negedge down_clk);
    resp_ready = '0;
    req        = 4'b0100;
    wait_valid(cyc);
    check("after_to_valid", 64'(resp_valid), 64'b0100);
    check("after_to_err", 64'(resp_err), 64'd0);
    check("after_to_data", 64'(resp_data), 64'h11);
    finish_job(4'b0100);
    @(negedge down_clk);

    // Stale done holds the FSM in START.
    reset_dut();
    stuck_done = 1'b1;
    set_chan(0, 16'd3, 32'h10);
    s0  = starts;
    req = 4'b0001;
    repeat (10) @(negedge down_clk);
    check("stale_no_start", 64'(starts - s0), 64'd0);
    check("stale_busy", 64'(busy), 64'd1);
    stuck_done = 1'b0;
    #1;
    check("stale_release_start", 64'(eng_start), 64'd1);
    wait_valid(cyc);
    check("stale_data", 64'(resp_data), 64'h33);
    finish_job(4'b0001);
    @(negedge down_clk);

    // Reset mid-RUN; the rr pointer must return to NUM_REQ-1.
    set_chan(1, 16'd2, 32'h20);
    req = 4'b0010;
    wait_valid(cyc);
    finish_job(4'b0010);
    set_chan(2, 16'd2, 32'h30);
    req = 4'b0100;
    wait_start(cyc);
    repeat (3) @(negedge down_clk);
    RST = 1'b1;
    #1;
    check("rst_run_busy", 64'(busy), 64'd0);
    check("rst_run_ctrl", {grant, resp_valid, eng_start, resp_err, eng_max_iteration}, 64'd0);
    check("rst_run_data", {eng_data_in, resp_data}, 64'd0);
    @(negedge down_clk);
    RST = 1'b0;
    req = '0;
    repeat (20) @(negedge down_clk);
    req = 4'b0110;
    @(negedge down_clk);
    check("rst_ptr_grant", 64'(grant), 64'b0010);
    wait_valid(cyc);
    finish_job(grant);
    @(negedge down_clk);

    // Withdrawal during RESP.
    reset_dut();
    set_chan(1, 16'd1, 32'h7);
    req = 4'b0010;
    wait_valid(cyc);
    check("wd_valid", 64'(resp_valid), 64'b0010);
    req = '0;
    @(negedge down_clk);
    check("wd_cleared", {grant, resp_valid}, 64'd0);
    check("wd_busy", 64'(busy), 64'd0);
    req = 4'b0110;
    @(negedge down_clk);
    check("wd_last_grant", 64'(grant), 64'b0100);
    wait_valid(cyc);
    finish_job(grant);
    repeat (2) @(negedge down_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
